// File: rtl/cnu_pkg.sv
// Shared constants, state type and helpers for the serial min-sum check-node sequencer.
package cnu_pkg;

    localparam int GRP = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // All-ones magnitude of width w; callers slice the low w bits.
    function automatic logic [31:0] mag_max(input int w);
        if (w >= 32) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/cnu_merge2.sv
// Merges a running (min1, min2, idx) triple with one beat's sorted (b1, b2, bidx) triple.
module cnu_merge2 #(
    parameter int DATA_W = 9,
    parameter int IDX_W  = 5
) (
    input  logic [DATA_W-1:0] r1_i,
    input  logic [DATA_W-1:0] r2_i,
    input  logic [IDX_W-1:0]  ridx_i,
    input  logic [DATA_W-1:0] b1_i,
    input  logic [DATA_W-1:0] b2_i,
    input  logic [IDX_W-1:0]  bidx_i,
    output logic [DATA_W-1:0] m1_o,
    output logic [DATA_W-1:0] m2_o,
    output logic [IDX_W-1:0]  midx_o
);

    // Strict compares keep the earlier global index on ties.
    always_comb begin
        m1_o   = r1_i;
        m2_o   = r2_i;
        midx_o = ridx_i;
        if (b1_i < r1_i) begin
            m1_o   = b1_i;
            midx_o = bidx_i;
            m2_o   = (b2_i < r1_i) ? b2_i : r1_i;
        end else begin
            m2_o   = (b1_i < r2_i) ? b1_i : r2_i;
        end
    end

endmodule

// File: rtl/cnu_min_seq.sv
// Serial min-sum check-node sequencer: tracks min1/min2/idx over a row of 3-lane beats.
// Optional lane sign tracking (in_sign/out_sign) is compiled in with CNU_SIGN_EN.
//
// state | meaning
// IDLE  | waiting for first beat of a row
// ACC   | row in progress, running minima valid
// HOLD  | row result presented on out_*, input stalled
module cnu_min_seq
    import cnu_pkg::*;
#(
    parameter int DATA_W    = 9,
    parameter int MAX_BEATS = 8,
    parameter int IDX_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [GRP*DATA_W-1:0] in_data,
    input  logic [GRP-1:0]        in_mask,
    input  logic                  in_last,
`ifdef CNU_SIGN_EN
    input  logic [GRP-1:0]        in_sign,
    output logic                  out_sign,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_min1,
    output logic [DATA_W-1:0]     out_min2,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_ovf
);

    localparam int                CNT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [31:0]       MAG_ALL  = mag_max(DATA_W);
    localparam logic [DATA_W-1:0] MAG_ONES = MAG_ALL[DATA_W-1:0];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [DATA_W-1:0] min1_q, min1_d, min2_q, min2_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] lane_v [GRP];
    logic [DATA_W-1:0] b1, b2;
    logic [1:0]        lane_sel;
    logic [IDX_W-1:0]  bidx;
    logic [DATA_W-1:0] m1, m2;
    logic [IDX_W-1:0]  midx;
    logic              accept;
    logic [CNT_W-1:0]  beat_nxt;
    logic              at_max;

    // Masked lanes read as all-ones so they can never take min1.
    always_comb begin
        for (int k = 0; k < GRP; k++) begin
            lane_v[k] = in_mask[k] ? in_data[k*DATA_W +: DATA_W] : MAG_ONES;
        end
    end

    always_comb begin
        lane_sel = 2'd0;
        b1       = lane_v[0];
        b2       = (lane_v[1] < lane_v[2]) ? lane_v[1] : lane_v[2];
        if (lane_v[0] <= lane_v[1] && lane_v[0] <= lane_v[2]) begin
            lane_sel = 2'd0;
            b1       = lane_v[0];
            b2       = (lane_v[1] < lane_v[2]) ? lane_v[1] : lane_v[2];
        end else if (lane_v[1] <= lane_v[2]) begin
            lane_sel = 2'd1;
            b1       = lane_v[1];
            b2       = (lane_v[0] < lane_v[2]) ? lane_v[0] : lane_v[2];
        end else begin
            lane_sel = 2'd2;
            b1       = lane_v[2];
            b2       = (lane_v[0] < lane_v[1]) ? lane_v[0] : lane_v[1];
        end
    end

    assign bidx = IDX_W'(32'(beat_q) * GRP + 32'(lane_sel));

    cnu_merge2 #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_merge (
        .r1_i   (r1_q),
        .r2_i   (r2_q),
        .ridx_i (ridx_q),
        .b1_i   (b1),
        .b2_i   (b2),
        .bidx_i (bidx),
        .m1_o   (m1),
        .m2_o   (m2),
        .midx_o (midx)
    );

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign beat_nxt  = beat_q + CNT_W'(1);
    assign at_max    = (beat_nxt == CNT_W'(MAX_BEATS));

`ifdef CNU_SIGN_EN
    logic rsign_q, rsign_d, osign_q, osign_d;
    logic bsign;
    assign bsign    = ^(in_sign & in_mask);
    assign out_sign = osign_q;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        ridx_d  = ridx_q;
        min1_d  = min1_q;
        min2_d  = min2_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
`ifdef CNU_SIGN_EN
        rsign_d = rsign_q;
        osign_d = osign_q;
`endif
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    if (in_last || at_max) begin
                        state_d = HOLD;
                        min1_d  = m1;
                        min2_d  = m2;
                        idx_d   = midx;
                        ovf_d   = at_max && !in_last;
                        beat_d  = '0;
                        r1_d    = MAG_ONES;
                        r2_d    = MAG_ONES;
                        ridx_d  = '0;
`ifdef CNU_SIGN_EN
                        osign_d = rsign_q ^ bsign;
                        rsign_d = 1'b0;
`endif
                    end else begin
                        state_d = ACC;
                        beat_d  = beat_nxt;
                        r1_d    = m1;
                        r2_d    = m2;
                        ridx_d  = midx;
`ifdef CNU_SIGN_EN
                        rsign_d = rsign_q ^ bsign;
`endif
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            r1_q    <= MAG_ONES;
            r2_q    <= MAG_ONES;
            ridx_q  <= '0;
            min1_q  <= '0;
            min2_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef CNU_SIGN_EN
            rsign_q <= 1'b0;
            osign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            ridx_q  <= ridx_d;
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
`ifdef CNU_SIGN_EN
            rsign_q <= rsign_d;
            osign_q <= osign_d;
`endif
        end
    end

    assign out_min1 = min1_q;
    assign out_min2 = min2_q;
    assign out_idx  = idx_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_cnu_min_seq.sv
// Directed self-checking bench for cnu_min_seq with hand-computed row results.
module tb_cnu_min_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] in_data = '0;
    logic [2:0]  in_mask = '0;
    logic        in_last = 1'b0;
    logic [2:0]  in_sign = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  out_min1;
    logic [8:0]  out_min2;
    logic [4:0]  out_idx;
    logic        out_ovf;
`ifdef CNU_SIGN_EN
    logic        out_sign;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cnu_min_seq #(
        .DATA_W    (9),
        .MAX_BEATS (8),
        .IDX_W     (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_last   (in_last),
`ifdef CNU_SIGN_EN
        .in_sign   (in_sign),
        .out_sign  (out_sign),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min1  (out_min1),
        .out_min2  (out_min2),
        .out_idx   (out_idx),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [8:0] d0, input logic [8:0] d1, input logic [8:0] d2,
                        input logic [2:0] m, input logic [2:0] s, input logic last);
        in_data  = {d2, d1, d0};
        in_mask  = m;
        in_sign  = s;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic row_result(input string tag, input logic [8:0] m1, input logic [8:0] m2,
                              input logic [4:0] idx, input logic ovf);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_min1"},  32'(out_min1),  32'(m1));
        check({tag, "_min2"},  32'(out_min2),  32'(m2));
        check({tag, "_idx"},   32'(out_idx),   32'(idx));
        check({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        // reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_min1",      32'(out_min1),  32'd0);
        check("rst_min2",      32'(out_min2),  32'd0);
        check("rst_idx",       32'(out_idx),   32'd0);
        check("rst_ovf",       32'(out_ovf),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single beat, result the cycle after accept
        beat(9'd5, 9'd2, 9'd7, 3'b111, 3'b000, 1'b1);
        row_result("single", 9'd2, 9'd5, 5'd1, 1'b0);
        check("single_in_ready_hold", 32'(in_ready), 32'd0);
        handshake();
        check("single_after_valid", 32'(out_valid), 32'd0);
        check("single_after_ready", 32'(in_ready),  32'd1);
        check("single_held_min1",   32'(out_min1),  32'd2);

        // two beats with out_ready tied high: one HOLD cycle
        out_ready = 1'b1;
        beat(9'd9, 9'd4, 9'd6, 3'b111, 3'b000, 1'b0);
        check("two_mid_valid", 32'(out_valid), 32'd0);
        beat(9'd3, 9'd8, 9'd4, 3'b111, 3'b000, 1'b1);
        row_result("two", 9'd3, 9'd4, 5'd3, 1'b0);
        @(posedge clk);
        #1;
        check("two_one_hold_cycle", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // ties keep the earliest index
        beat(9'd4, 9'd6, 9'd7, 3'b111, 3'b000, 1'b0);
        beat(9'd4, 9'd4, 9'd9, 3'b111, 3'b000, 1'b1);
        row_result("tie", 9'd4, 9'd4, 5'd0, 1'b0);
        handshake();

        // partial mask
        beat(9'd10, 9'd12, 9'd1, 3'b011, 3'b000, 1'b1);
        row_result("partial", 9'd10, 9'd12, 5'd0, 1'b0);
        handshake();

        // fully masked beat still advances the beat counter
        beat(9'd3, 9'd3, 9'd3, 3'b000, 3'b000, 1'b0);
        beat(9'd7, 9'd2, 9'd9, 3'b111, 3'b000, 1'b1);
        row_result("mask0", 9'd2, 9'd7, 5'd4, 1'b0);
        handshake();

        // every lane masked
        beat(9'd1, 9'd1, 9'd1, 3'b000, 3'b000, 1'b1);
        row_result("allmask", 9'd511, 9'd511, 5'd0, 1'b0);
        handshake();

        // force-termination at MAX_BEATS, then stall with out_ready low
        for (int k = 0; k < 8; k++) begin
            if (k == 6) beat(9'd15, 9'd8, 9'd9, 3'b111, 3'b000, 1'b0);
            else        beat(9'(k + 10), 9'd50, 9'd60, 3'b111, 3'b000, 1'b0);
            if (k == 6) check("ovf_not_yet_valid", 32'(out_valid), 32'd0);
        end
        row_result("ovf", 9'd8, 9'd9, 5'd19, 1'b1);
        in_data  = '0;
        in_mask  = 3'b111;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_min1",      32'(out_min1),  32'd8);
            check("stall_min2",      32'(out_min2),  32'd9);
            check("stall_idx",       32'(out_idx),   32'd19);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake();
        check("ovf_released", 32'(out_valid), 32'd0);

        // reset mid-row aborts it
        beat(9'd0, 9'd5, 9'd5, 3'b111, 3'b000, 1'b0);
        beat(9'd0, 9'd5, 9'd5, 3'b111, 3'b000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready),  32'd1);
        check("abort_min1",  32'(out_min1),  32'd0);
        check("abort_ovf",   32'(out_ovf),   32'd0);
        @(posedge clk);
        #1;
        check("abort_no_valid", 32'(out_valid), 32'd0);
        beat(9'd1, 9'd2, 9'd3, 3'b111, 3'b101, 1'b1);
        row_result("after_abort", 9'd1, 9'd2, 5'd0, 1'b0);
`ifdef CNU_SIGN_EN
        check("after_abort_sign", 32'(out_sign), 32'd0);
`endif
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
